// File: rtl/executs_muldiv_if.sv
// Request/result bundle between the execute stage and the iterative
// multiply/divide unit.
interface executs_muldiv_if #(parameter int WIDTH = 32);
  logic             Md_start;
  logic [5:0]       Function_opcode;
  logic [WIDTH-1:0] Read_data_1;
  logic [WIDTH-1:0] Read_data_2;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             Md_busy;
  logic             Md_done;

  modport master (
    output Md_start, Function_opcode, Read_data_1, Read_data_2,
    input  HI, LO, Md_busy, Md_done
  );

  modport slave (
    input  Md_start, Function_opcode, Read_data_1, Read_data_2,
    output HI, LO, Md_busy, Md_done
  );
endinterface

// File: rtl/executs_muldiv.sv
// Radix-2 iterative mult/multu/div/divu with HI/LO registers and mthi/mtlo.
// One 2*WIDTH accumulator serves as product register or {remainder, quotient}.
module executs_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  executs_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sg);
    return (sg && v[WIDTH-1]) ? neg_w(v) : v;
  endfunction

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [2*WIDTH-1:0] acc_r, acc_s;
  logic [WIDTH-1:0]   opb_r, opb_s;
  logic [WIDTH-1:0]   hi_r, hi_s, lo_r, lo_s;
  logic               is_div_r, is_div_s;
  logic               neg_res_r, neg_res_s;
  logic               neg_rem_r, neg_rem_s;
  logic               done_r, done_s;

  logic               sg_s;
  logic [WIDTH-1:0]   ma_s, mb_s;
  logic               sign_a_s, sign_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH+1:0]   diff_s;
  logic [2*WIDTH-1:0] div_next_s;

  // Operand preparation: signed variants are the even funct codes
  assign sg_s     = ~bus.Function_opcode[0];
  assign sign_a_s = bus.Read_data_1[WIDTH-1];
  assign sign_b_s = bus.Read_data_2[WIDTH-1];
  assign ma_s     = magnitude(bus.Read_data_1, sg_s);
  assign mb_s     = magnitude(bus.Read_data_2, sg_s);

  // Shift-add: add multiplicand into the upper half when the low bit is set
  assign mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc_r[0] ? opb_r : {WIDTH{1'b0}})};
  assign mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};

  // Restoring divide; a zero divisor naturally yields all-ones quotient and
  // leaves the dividend as remainder
  assign rem_sh_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
  assign diff_s     = {1'b0, rem_sh_s} - {2'b00, opb_r};
  assign div_next_s = diff_s[WIDTH+1]
                    ? {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0}
                    : {diff_s[WIDTH-1:0],   acc_r[WIDTH-2:0], 1'b1};

  // Next-state and datapath updates
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    acc_s     = acc_r;
    opb_s     = opb_r;
    hi_s      = hi_r;
    lo_s      = lo_r;
    is_div_s  = is_div_r;
    neg_res_s = neg_res_r;
    neg_rem_s = neg_rem_r;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.Md_start) begin
          case (bus.Function_opcode)
            F_MTHI: begin
              hi_s   = bus.Read_data_1;
              done_s = 1'b1;
            end
            F_MTLO: begin
              lo_s   = bus.Read_data_1;
              done_s = 1'b1;
            end
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              is_div_s  = bus.Function_opcode[1];
              neg_res_s = sg_s & (sign_a_s ^ sign_b_s)
                        & (~bus.Function_opcode[1] | (|bus.Read_data_2));
              neg_rem_s = sg_s & sign_a_s;
              acc_s     = {{WIDTH{1'b0}}, ma_s};
              opb_s     = mb_s;
              cnt_s     = {CW{1'b0}};
              state_s   = CALC;
            end
            default: begin
              state_s = IDLE;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        acc_s = is_div_r ? div_next_s : mul_next_s;
        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_r == LAST_ITER) begin
          state_s = FIX;
        end else begin
          state_s = CALC;
        end
      end
      FIX: begin
        if (is_div_r) begin
          lo_s = neg_res_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
          hi_s = neg_rem_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
        end else begin
          {hi_s, lo_s} = neg_res_r ? neg_2w(acc_r) : acc_r;
        end
        done_s  = 1'b1;
        cnt_s   = {CW{1'b0}};
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      opb_r     <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      acc_r     <= acc_s;
      opb_r     <= opb_s;
      hi_r      <= hi_s;
      lo_r      <= lo_s;
      is_div_r  <= is_div_s;
      neg_res_r <= neg_res_s;
      neg_rem_r <= neg_rem_s;
      done_r    <= done_s;
    end
  end

  assign bus.HI      = hi_r;
  assign bus.LO      = lo_r;
  assign bus.Md_done = done_r;
  assign bus.Md_busy = (state_r != IDLE);
endmodule

// File: tb/tb_executs_muldiv.sv
// Table-driven and scoreboard bench for executs_muldiv (WIDTH = 32).
module tb_executs_muldiv;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;
  vec_t vecs[12];

  executs_muldiv_if #(.WIDTH(32)) bus();

  executs_muldiv #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = 64'sd0;
    m  = 64'sd0;
    case (op)
      F_MULT:  r = 64'(sa * sb);
      F_MULTU: r = {32'd0, a} * {32'd0, b};
      F_DIV: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      F_DIVU: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Issue one op, push its expectation, then watch busy/hold/done until completion
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv, input int inject_cyc);
    int cyc, busy_cnt, exp_lat, exp_busy;
    bit hold_ok, got_done;
    logic [63:0] e;
    exp_lat  = (op == F_MTHI || op == F_MTLO) ? 1 : 34;
    exp_busy = (op == F_MTHI || op == F_MTLO) ? 0 : 33;
    @(negedge clock);
    bus.Md_start = 1'b1;
    bus.Function_opcode = op;
    bus.Read_data_1 = a;
    bus.Read_data_2 = b;
    exp_q.push_back(expv);
    @(posedge clock);
    #1;
    bus.Md_start = 1'b0;
    bus.Read_data_1 = $urandom;
    bus.Read_data_2 = $urandom;
    cyc = 0; busy_cnt = 0; hold_ok = 1'b1; got_done = 1'b0;
    while (!got_done && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (bus.Md_busy) busy_cnt++;
      if (bus.Md_done) begin
        got_done = 1'b1;
        e = exp_q.pop_front();
        check("HI", {32'd0, bus.HI}, {32'd0, e[63:32]});
        check("LO", {32'd0, bus.LO}, {32'd0, e[31:0]});
        check("latency", 64'(cyc), 64'(exp_lat));
        cur_hi = e[63:32];
        cur_lo = e[31:0];
      end else if (bus.HI !== cur_hi || bus.LO !== cur_lo) begin
        hold_ok = 1'b0;
      end
      if (cyc == inject_cyc) begin
        bus.Md_start = 1'b1;
        bus.Function_opcode = F_DIV;
        bus.Read_data_1 = 32'd100;
        bus.Read_data_2 = 32'd3;
      end else if (cyc == inject_cyc + 1) begin
        bus.Md_start = 1'b0;
      end
    end
    if (!got_done) begin
      check("timeout", 64'd0, 64'd1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
    end
    check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    check("hold", {63'd0, hold_ok}, 64'd1);
    @(negedge clock);
    check("done_pulse", {63'd0, bus.Md_done}, 64'd0);
  endtask

  initial begin
    bit seen;
    logic [5:0] rop;
    logic [31:0] ra, rb;
    vecs[0]  = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{F_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2]  = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4]  = '{F_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[5]  = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6]  = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7]  = '{F_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[8]  = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9]  = '{F_MULTU, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{F_MULT,  32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    vecs[11] = '{F_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};

    bus.Md_start = 1'b0;
    bus.Function_opcode = 6'd0;
    bus.Read_data_1 = 32'd0;
    bus.Read_data_2 = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_HI", {32'd0, bus.HI}, 64'd0);
    check("rst_LO", {32'd0, bus.LO}, 64'd0);
    check("rst_busy", {63'd0, bus.Md_busy}, 64'd0);
    check("rst_done", {63'd0, bus.Md_done}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, -5);

    // mthi then mtlo on back-to-back cycles
    @(negedge clock);
    bus.Md_start = 1'b1;
    bus.Function_opcode = F_MTHI;
    bus.Read_data_1 = 32'h1234_5678;
    @(negedge clock);
    check("mthi_done", {63'd0, bus.Md_done}, 64'd1);
    check("mthi_busy", {63'd0, bus.Md_busy}, 64'd0);
    check("mthi_HI", {32'd0, bus.HI}, 64'h1234_5678);
    bus.Function_opcode = F_MTLO;
    bus.Read_data_1 = 32'hCAFE_BABE;
    @(negedge clock);
    check("mtlo_done", {63'd0, bus.Md_done}, 64'd1);
    check("mtlo_busy", {63'd0, bus.Md_busy}, 64'd0);
    check("mtlo_LO", {32'd0, bus.LO}, 64'hCAFE_BABE);
    check("mtlo_HI", {32'd0, bus.HI}, 64'h1234_5678);
    bus.Md_start = 1'b0;
    @(negedge clock);
    check("move_done_low", {63'd0, bus.Md_done}, 64'd0);
    cur_hi = 32'h1234_5678;
    cur_lo = 32'hCAFE_BABE;

    // Unknown funct: nothing happens
    bus.Md_start = 1'b1;
    bus.Function_opcode = 6'b100000;
    bus.Read_data_1 = 32'hDEAD_BEEF;
    @(negedge clock);
    bus.Md_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.Md_done || bus.Md_busy) seen = 1'b1;
      @(negedge clock);
    end
    check("bad_op_quiet", {63'd0, seen}, 64'd0);
    check("bad_op_HI", {32'd0, bus.HI}, 64'h1234_5678);

    // Start during iteration 5 must be ignored
    run_op(F_MULTU, 32'd6, 32'd7, 64'd42, 5);

    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(3))
        0: rop = F_MULT;
        1: rop = F_MULTU;
        2: rop = F_DIV;
        default: rop = F_DIVU;
      endcase
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i == 5) ? 32'd1 << $urandom_range(31) : $urandom);
      run_op(rop, ra, rb, model(rop, ra, rb), -5);
    end

    // Reset at iteration 10 discards the operation
    @(negedge clock);
    bus.Md_start = 1'b1;
    bus.Function_opcode = F_MULTU;
    bus.Read_data_1 = 32'd6;
    bus.Read_data_2 = 32'd7;
    @(posedge clock);
    #1;
    bus.Md_start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_busy", {63'd0, bus.Md_busy}, 64'd0);
    check("midrst_HI", {32'd0, bus.HI}, 64'd0);
    check("midrst_LO", {32'd0, bus.LO}, 64'd0);
    check("midrst_done", {63'd0, bus.Md_done}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.Md_done || bus.Md_busy) seen = 1'b1;
    end
    check("midrst_no_done", {63'd0, seen}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
